// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//   Registered, handshaked RV32I decode stage between fetch and execute.
//   The instruction word is decoded combinationally into a control bundle,
//   which is captured into a two-entry elastic buffer (main + skid entry).
//   Because of the skid entry, in_ready can be a register and the stage still
//   sustains one instruction per cycle.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake; in_ready == !skid_valid
//   in_instr, in_pc       instruction word and its PC
//   flush                 drop everything held plus any same-cycle input
//   out_valid/out_ready   execute handshake
//   out_pc, out_imm       bundle PC, sign-extended immediate (0 for R-type)
//   out_rs1/rs2/rd        register indices, 0 when the format lacks the field
//   out_alu_op            ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7
//                         OR=8 AND=9
//   out_op1_sel           0=rs1, 1=PC
//   out_op2_sel           0=rs2, 1=imm
//   out_wb_sel            00=ALU 01=mem 10=PC+4 11=imm
//   out_rf_wr_en, out_mem_rd_en, out_mem_wr_en
//   out_funct3            raw funct3 (mem size / branch condition)
//   out_branch, out_jal, out_jalr, out_illegal
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned ALU_OP_W         = 4,
    parameter bit          RD_ZERO_SUPPRESS = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_imm,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic                out_op1_sel,
    output logic                out_op2_sel,
    output logic [1:0]          out_wb_sel,
    output logic                out_rf_wr_en,
    output logic                out_mem_rd_en,
    output logic                out_mem_wr_en,
    output logic [2:0]          out_funct3,
    output logic                out_branch,
    output logic                out_jal,
    output logic                out_jalr,
    output logic                out_illegal
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_e            alu_op;
        logic            op1_sel;
        logic            op2_sel;
        wb_e             wb_sel;
        logic            rf_wr_en;
        logic            mem_rd_en;
        logic            mem_wr_en;
        logic [2:0]      funct3;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            illegal;
    } bundle_t;

    // funct3 -> ALU op for the register/immediate ALU groups; the funct7
    // qualifier (SUB/SRA) is applied by the caller.
    function automatic alu_e alu_from_funct3(input logic [2:0] f3);
        alu_e op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'h000};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    logic        use_rs1, use_rs2, use_rd, wr_fmt;
    logic        is_load, is_store, is_branch, is_jal, is_jalr;
    logic        dec_illegal, dec_op1_sel, dec_op2_sel;
    logic [31:0] dec_imm32;
    alu_e        dec_alu;
    wb_e         dec_wb;
    bundle_t     dec;

    always_comb begin
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        use_rd      = 1'b0;
        wr_fmt      = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        dec_illegal = 1'b0;
        dec_op1_sel = 1'b0;
        dec_op2_sel = 1'b0;
        dec_imm32   = '0;
        dec_alu     = ALU_ADD;
        dec_wb      = WB_ALU;

        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                wr_fmt  = 1'b1;
                dec_alu = alu_from_funct3(funct3);
                if (funct7 == 7'h00) begin
                    dec_alu = alu_from_funct3(funct3);
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    dec_alu = ALU_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    dec_alu = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                wr_fmt      = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_i;
                dec_alu     = alu_from_funct3(funct3);
                // Only the shift forms constrain imm[11:5].
                if (funct3 == 3'd1 && funct7 != 7'h00) begin
                    dec_illegal = 1'b1;
                end
                if (funct3 == 3'd5) begin
                    if (funct7 == 7'h20) begin
                        dec_alu = ALU_SRA;
                    end else if (funct7 != 7'h00) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                wr_fmt      = 1'b1;
                is_load     = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_i;
                dec_wb      = WB_MEM;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                is_store    = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_s;
                if (funct3 > 3'd2) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                is_branch = 1'b1;
                dec_imm32 = imm_b;
                dec_alu   = ALU_SUB;
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_JAL: begin
                use_rd      = 1'b1;
                wr_fmt      = 1'b1;
                is_jal      = 1'b1;
                dec_op1_sel = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_j;
                dec_wb      = WB_PC4;
            end
            OPC_JALR: begin
                use_rs1     = 1'b1;
                use_rd      = 1'b1;
                wr_fmt      = 1'b1;
                is_jalr     = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_i;
                dec_wb      = WB_PC4;
                if (funct3 != 3'd0) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                use_rd      = 1'b1;
                wr_fmt      = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_u;
                dec_wb      = WB_IMM;
            end
            OPC_AUIPC: begin
                use_rd      = 1'b1;
                wr_fmt      = 1'b1;
                dec_op1_sel = 1'b1;
                dec_op2_sel = 1'b1;
                dec_imm32   = imm_u;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec           = '0;
        dec.pc        = in_pc;
        dec.imm       = XLEN'($signed(dec_imm32));
        dec.rs1       = use_rs1 ? in_instr[19:15] : 5'd0;
        dec.rs2       = use_rs2 ? in_instr[24:20] : 5'd0;
        dec.rd        = use_rd  ? in_instr[11:7]  : 5'd0;
        dec.alu_op    = dec_alu;
        dec.op1_sel   = dec_op1_sel;
        dec.op2_sel   = dec_op2_sel;
        dec.wb_sel    = dec_wb;
        dec.funct3    = funct3;
        dec.illegal   = dec_illegal;
        // Side-effecting enables are squashed for illegal instructions so
        // execute can treat them as bubbles that still carry a PC.
        dec.rf_wr_en  = wr_fmt & ~dec_illegal &
                        ~(RD_ZERO_SUPPRESS && in_instr[11:7] == 5'd0);
        dec.mem_rd_en = is_load   & ~dec_illegal;
        dec.mem_wr_en = is_store  & ~dec_illegal;
        dec.branch    = is_branch & ~dec_illegal;
        dec.jal       = is_jal    & ~dec_illegal;
        dec.jalr      = is_jalr   & ~dec_illegal;
    end

    // ------------------------------------------------------------------
    // Two-entry elastic buffer: M drives the outputs, S catches the one
    // instruction that arrives while M is stalled.
    // ------------------------------------------------------------------
    bundle_t m_q, m_d, s_q, s_d;
    logic    m_valid_q, m_valid_d, s_valid_q, s_valid_d, in_ready_q;
    logic    accept, consume;

    assign accept  = in_valid & in_ready_q & ~flush;
    assign consume = m_valid_q & out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (accept) begin
            // in_ready is low whenever S is full, so an accept never has to
            // move S into M at the same time.
            if (!m_valid_q || consume) begin
                m_d       = dec;
                m_valid_d = 1'b1;
            end else begin
                s_d       = dec;
                s_valid_d = 1'b1;
            end
        end else if (consume) begin
            if (s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= ~s_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = m_valid_q;
    assign out_pc        = m_q.pc;
    assign out_imm       = m_q.imm;
    assign out_rs1       = m_q.rs1;
    assign out_rs2       = m_q.rs2;
    assign out_rd        = m_q.rd;
    assign out_alu_op    = ALU_OP_W'(m_q.alu_op);
    assign out_op1_sel   = m_q.op1_sel;
    assign out_op2_sel   = m_q.op2_sel;
    assign out_wb_sel    = m_q.wb_sel;
    assign out_rf_wr_en  = m_q.rf_wr_en;
    assign out_mem_rd_en = m_q.mem_rd_en;
    assign out_mem_wr_en = m_q.mem_wr_en;
    assign out_funct3    = m_q.funct3;
    assign out_branch    = m_q.branch;
    assign out_jal       = m_q.jal;
    assign out_jalr      = m_q.jalr;
    assign out_illegal   = m_q.illegal;

endmodule
